serial_rx: RTL and testbench
============================

# serial_rx

Framed serial receiver: samples a one-bit-per-clock serial line, detects a start bit, shifts in `WIDTH` data bits LSB-first, checks the stop bit, and presents the received word with a one-cycle valid strobe. It is the receiving end of the team's shift-register serial transmitter and sits directly on the transmitter's line output within the same clock domain. No oversampling and no synchronizer are used; the line is driven synchronously by the transmitter.

## Interface
- `WIDTH`, default 8: data bits per frame (legal range 2..16).
- `Clk`  in  1  rising-edge clock; one line bit per clock.
- `Reset`  in  1  asynchronous, active-low reset.
- `SerIn`  in  1  serial line; idle high.
- `Data`  out  `WIDTH`  last correctly received word.
- `Valid`  out  1  one-cycle pulse; `Data` was updated on the same edge.
- `FrameErr`  out  1  one-cycle pulse; stop bit was sampled low.
- `Busy`  out  1  high while a frame is being received (any state other than IDLE).
- `ParityErr`  out  1  present only with `PARITY_CHECK_EN`; one-cycle pulse on parity mismatch.

## Operation
- Frame format: start bit (0), `WIDTH` data bits LSB-first, optional even-parity bit (see Configuration), stop bit (1).
- Internal shift register `sh[WIDTH-1:0]`: on each DATA edge, `sh <= {SerIn, sh[WIDTH-1:1]}`.
- Bit counter: `$clog2(WIDTH)+1` bits, cleared on the start edge.
- States:
  - IDLE -> DATA when `SerIn`=0 is sampled.
  - DATA -> DATA while the counter is below `WIDTH-1`, incrementing the counter each edge. After the `WIDTH`-th data bit, DATA -> PARITY if the macro is defined, otherwise DATA -> STOP.
  - PARITY -> STOP always. Captures the parity bit.
  - STOP -> IDLE always.
- STOP with `SerIn`=1 (and parity good, if enabled): `Data <= sh` and `Valid` pulses.
- STOP with `SerIn`=0: `FrameErr` pulses and `Data` holds its value.
- Glitch filtering: none. A single low sample in IDLE starts a frame.
- Back-to-back frames: the next start bit may arrive on the cycle immediately after the stop bit.
- Reset asserted at any time: immediate return to IDLE. `Data`, `sh`, and the counter clear to 0. All pulse outputs and `Busy` go to 0. An aborted frame produces no pulse.
- Reset values: `Data`=0, `Valid`=0, `FrameErr`=0, `Busy`=0, `ParityErr`=0.

## Timing
- Start bit sampled at edge k.
- Data bit i sampled at edge k+1+i.
- Stop bit sampled at edge k+WIDTH+1, or k+WIDTH+2 with parity.
- `Valid`, `FrameErr`, and `ParityErr` are registered. Each is high for exactly the one cycle following the stop-sample edge.
- `Busy` rises after edge k and falls after the stop-sample edge.
- Frame period: WIDTH+2 clocks (WIDTH+3 with parity). Sustained throughput is one word per frame period.
- `Valid` and `FrameErr` are never high together.

## Configuration
- Macro: `PARITY_CHECK_EN`.
- Defined:
  - The PARITY state is present and the frame carries one even-parity bit between the data bits and the stop bit.
  - Parity check: XOR of the data bits and the parity bit must equal 0.
  - Mismatch with a good stop bit: `ParityErr` pulses; no `Valid`; `Data` holds.
  - Mismatch with a bad stop bit: both `ParityErr` and `FrameErr` pulse.
- Undefined: the PARITY state and the `ParityErr` port are both absent, and the frame is WIDTH+2 bits.

## Test plan
- Reset held low for 3 clocks, `SerIn`=1, then released -> all outputs 0; `Busy` stays 0 while the line idles.
- `WIDTH`=8, frame 0xA5 (line 0,1,0,1,0,0,1,0,1,1) -> `Data`=0xA5; `Valid` is high for one cycle, 10 clocks after the start edge.
- Frames 0x3C then 0xFF with no idle gap -> two `Valid` pulses 10 clocks apart; `Data` reads 0x3C, then 0xFF.
- Frame 0x5A with the stop bit driven 0 -> `FrameErr` pulses; no `Valid`; `Data` keeps its prior value (0xFF).
- Reset pulled low during data bit 4 of frame 0x81, then released, then a clean 0x42 frame -> no pulse for the aborted frame; `Data`=0 until 0x42 is received; `Valid` pulses once.
- With `PARITY_CHECK_EN`, frame 0x07 with parity bit 0 (wrong) and good stop -> `ParityErr` pulses; no `Valid`. The same frame with parity bit 1 -> `Valid`, `Data`=0x07.

Source files
------------

// File: rtl/serial_rx.sv
// Framed serial receiver: start bit, WIDTH data bits LSB-first, stop bit, one bit per clock.
// Define PARITY_CHECK_EN to expect an even-parity bit before the stop bit and expose o_parity_err.
module serial_rx #(
    parameter int WIDTH = 8
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_ser_in,
    output logic [WIDTH-1:0] o_data,
    output logic             o_valid,
    output logic             o_frame_err,
    output logic             o_busy
`ifdef PARITY_CHECK_EN
    ,
    output logic             o_parity_err
`endif
);

    localparam int CW = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_DATA   = 2'd1,
`ifdef PARITY_CHECK_EN
        S_PARITY = 2'd2,
`endif
        S_STOP   = 2'd3
    } state_t;

    state_t           r_state, w_state_nxt;
    logic [WIDTH-1:0] r_sh, w_sh_nxt;
    logic [CW-1:0]    r_cnt, w_cnt_nxt;
    logic [WIDTH-1:0] r_data, w_data_nxt;
    logic             r_valid, w_valid_nxt;
    logic             r_frame_err, w_frame_err_nxt;
    logic             r_busy;
`ifdef PARITY_CHECK_EN
    logic             r_par_bit, w_par_bit_nxt;
    logic             r_parity_err, w_parity_err_nxt;
    logic             w_par_ok;

    // Even parity over data plus received parity bit: zero means consistent.
    function automatic logic even_parity_ok(input logic [WIDTH-1:0] data, input logic par);
        return ((^data) ^ par) == 1'b0;
    endfunction

    assign w_par_ok = even_parity_ok(r_sh, r_par_bit);
`endif

    // Next-state, shift register, counter and output pulse decode.
    always_comb begin
        w_state_nxt     = r_state;
        w_sh_nxt        = r_sh;
        w_cnt_nxt       = r_cnt;
        w_data_nxt      = r_data;
        w_valid_nxt     = 1'b0;
        w_frame_err_nxt = 1'b0;
`ifdef PARITY_CHECK_EN
        w_par_bit_nxt    = r_par_bit;
        w_parity_err_nxt = 1'b0;
`endif
        case (r_state)
            S_IDLE: begin
                if (i_ser_in == 1'b0) begin
                    w_state_nxt = S_DATA;
                    w_cnt_nxt   = {CW{1'b0}};
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_DATA: begin
                w_sh_nxt = {i_ser_in, r_sh[WIDTH-1:1]};
                if (r_cnt < LAST_BIT) begin
                    w_cnt_nxt = r_cnt + {{(CW-1){1'b0}}, 1'b1};
                end else begin
`ifdef PARITY_CHECK_EN
                    w_state_nxt = S_PARITY;
`else
                    w_state_nxt = S_STOP;
`endif
                end
            end
`ifdef PARITY_CHECK_EN
            S_PARITY: begin
                w_par_bit_nxt = i_ser_in;
                w_state_nxt   = S_STOP;
            end
`endif
            S_STOP: begin
                w_state_nxt     = S_IDLE;
                w_frame_err_nxt = ~i_ser_in;
`ifdef PARITY_CHECK_EN
                w_parity_err_nxt = ~w_par_ok;
                if (i_ser_in && w_par_ok) begin
`else
                if (i_ser_in) begin
`endif
                    w_data_nxt  = r_sh;
                    w_valid_nxt = 1'b1;
                end else begin
                    w_data_nxt  = r_data;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // State and datapath registers; every output is driven from a flop.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state     <= S_IDLE;
            r_sh        <= {WIDTH{1'b0}};
            r_cnt       <= {CW{1'b0}};
            r_data      <= {WIDTH{1'b0}};
            r_valid     <= 1'b0;
            r_frame_err <= 1'b0;
            r_busy      <= 1'b0;
`ifdef PARITY_CHECK_EN
            r_par_bit    <= 1'b0;
            r_parity_err <= 1'b0;
`endif
        end else begin
            r_state     <= w_state_nxt;
            r_sh        <= w_sh_nxt;
            r_cnt       <= w_cnt_nxt;
            r_data      <= w_data_nxt;
            r_valid     <= w_valid_nxt;
            r_frame_err <= w_frame_err_nxt;
            r_busy      <= (w_state_nxt != S_IDLE);
`ifdef PARITY_CHECK_EN
            r_par_bit    <= w_par_bit_nxt;
            r_parity_err <= w_parity_err_nxt;
`endif
        end
    end

    assign o_data      = r_data;
    assign o_valid     = r_valid;
    assign o_frame_err = r_frame_err;
    assign o_busy      = r_busy;
`ifdef PARITY_CHECK_EN
    assign o_parity_err = r_parity_err;
`endif

endmodule

// File: tb/tb_serial_rx.sv
// Directed self-checking bench for serial_rx (WIDTH=8); parity steps run only with PARITY_CHECK_EN.
module tb_serial_rx;

    logic       clk;
    logic       rst_n;
    logic       ser_in;
    logic [7:0] data;
    logic       valid;
    logic       frame_err;
    logic       busy;
`ifdef PARITY_CHECK_EN
    logic       parity_err;
`endif

    int checks;
    int failures;

    serial_rx #(.WIDTH(8)) dut (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .i_ser_in    (ser_in),
        .o_data      (data),
        .o_valid     (valid),
        .o_frame_err (frame_err),
        .o_busy      (busy)
`ifdef PARITY_CHECK_EN
        ,
        .o_parity_err(parity_err)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Present one line bit; the DUT samples it on the next rising edge.
    task automatic drive_bit(input logic b);
        ser_in = b;
        @(negedge clk);
    endtask

    // Start, data LSB-first, [parity], stop. Returns right after the stop-sample edge.
    task automatic send_frame(input logic [7:0] d, input logic stop_bit, input logic flip_par);
        drive_bit(1'b0);
        check("busy_after_start", {31'd0, busy}, 32'd1);
        check("valid_low_in_frame", {31'd0, valid}, 32'd0);
        for (int i = 0; i < 8; i++) drive_bit(d[i]);
`ifdef PARITY_CHECK_EN
        drive_bit((^d) ^ flip_par);
`endif
        check("valid_low_before_stop", {31'd0, valid}, 32'd0);
        drive_bit(stop_bit);
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        ser_in   = 1'b1;
        rst_n    = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_data", {24'd0, data}, 32'h0);
        check("rst_valid", {31'd0, valid}, 32'd0);
        check("rst_ferr", {31'd0, frame_err}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        check("idle_busy", {31'd0, busy}, 32'd0);
        check("idle_valid", {31'd0, valid}, 32'd0);

        // Frame 0xA5
        send_frame(8'hA5, 1'b1, 1'b0);
        check("a5_valid", {31'd0, valid}, 32'd1);
        check("a5_data", {24'd0, data}, 32'hA5);
        check("a5_ferr", {31'd0, frame_err}, 32'd0);
        check("a5_busy_fall", {31'd0, busy}, 32'd0);
        drive_bit(1'b1);
        check("a5_valid_one_cycle", {31'd0, valid}, 32'd0);

        // Back-to-back 0x3C, 0xFF
        send_frame(8'h3C, 1'b1, 1'b0);
        check("3c_valid", {31'd0, valid}, 32'd1);
        check("3c_data", {24'd0, data}, 32'h3C);
        send_frame(8'hFF, 1'b1, 1'b0);
        check("ff_valid", {31'd0, valid}, 32'd1);
        check("ff_data", {24'd0, data}, 32'hFF);
        drive_bit(1'b1);
        check("ff_valid_one_cycle", {31'd0, valid}, 32'd0);

        // Framing error on 0x5A
        send_frame(8'h5A, 1'b0, 1'b0);
        check("5a_ferr", {31'd0, frame_err}, 32'd1);
        check("5a_no_valid", {31'd0, valid}, 32'd0);
        check("5a_data_hold", {24'd0, data}, 32'hFF);
        drive_bit(1'b1);
        check("5a_ferr_one_cycle", {31'd0, frame_err}, 32'd0);
        check("5a_busy", {31'd0, busy}, 32'd0);

        // Reset during data bit 4 of 0x81
        drive_bit(1'b0);
        drive_bit(1'b1);
        drive_bit(1'b0);
        drive_bit(1'b0);
        drive_bit(1'b0);
        ser_in = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        check("abort_busy", {31'd0, busy}, 32'd0);
        check("abort_data", {24'd0, data}, 32'h0);
        @(negedge clk);
        ser_in = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 12; i++) begin
            drive_bit(1'b1);
            check("abort_no_valid", {31'd0, valid}, 32'd0);
            check("abort_no_ferr", {31'd0, frame_err}, 32'd0);
        end
        check("abort_data_zero", {24'd0, data}, 32'h0);
        send_frame(8'h42, 1'b1, 1'b0);
        check("42_valid", {31'd0, valid}, 32'd1);
        check("42_data", {24'd0, data}, 32'h42);
        drive_bit(1'b1);
        check("42_valid_one_cycle", {31'd0, valid}, 32'd0);

`ifdef PARITY_CHECK_EN
        send_frame(8'h07, 1'b1, 1'b1);
        check("par_bad_perr", {31'd0, parity_err}, 32'd1);
        check("par_bad_no_valid", {31'd0, valid}, 32'd0);
        check("par_bad_data_hold", {24'd0, data}, 32'h42);
        drive_bit(1'b1);
        check("par_bad_one_cycle", {31'd0, parity_err}, 32'd0);
        send_frame(8'h07, 1'b1, 1'b0);
        check("par_good_valid", {31'd0, valid}, 32'd1);
        check("par_good_data", {24'd0, data}, 32'h07);
        check("par_good_perr", {31'd0, parity_err}, 32'd0);
        drive_bit(1'b1);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
